ao_array_pipe: RTL

Parametrised, pipelined AND-OR array for the synthesised-netlist flow. Each of WIDTH lanes computes one of four selectable AND/OR (with optional inversion) functions over NGRP groups of GSIZE inputs, plus one extra input per lane. The function is selected at run time. Results pass through a DEPTH-stage valid/ready pipeline. An output toggle counter gives switching-activity estimates for the reachability/power studies.

---
 rtl/ao_array_pkg.sv | 58 +++++
 rtl/ao_array_pipe_if.sv | 32 +++
 rtl/ao_pipe_stage.sv | 38 +++
 rtl/ao_array_pipe.sv | 96 +++++++++
 4 files changed

// File: rtl/ao_array_pkg.sv
// ao_array_pkg: shared types, constants and the per-lane AND-OR evaluator for ao_array_pipe.
//   mode_e   : function select (AO, AOI, OA, OAI)
//   ModeW    : width of the mode field
//   ao_eval  : pure per-lane function over up to MaxGrp groups of up to MaxGsz terms
package ao_array_pkg;

  localparam int unsigned ModeW    = 2;
  localparam int unsigned MaxGrp   = 8;
  localparam int unsigned MaxGsz   = 8;
  localparam int unsigned MaxTerms = MaxGrp * MaxGsz;

  typedef enum logic [ModeW-1:0] {
    ModeAo  = 2'd0,
    ModeAoi = 2'd1,
    ModeOa  = 2'd2,
    ModeOai = 2'd3
  } mode_e;

  // Term t of group g sits at bits[g*gsize + t]; bits above ngrp*gsize are ignored.
  function automatic logic ao_eval(input mode_e             mode,
                                   input logic [MaxTerms-1:0] bits,
                                   input int unsigned       ngrp,
                                   input int unsigned       gsize,
                                   input logic              ext);
    logic [MaxTerms-1:0] sh;
    logic                all1;
    logic                any1;
    logic                ao;
    logic                oa;
    logic                res;
    ao  = 1'b0;
    oa  = 1'b1;
    res = 1'b0;
    for (int unsigned g = 0; g < MaxGrp; g++) begin
      if (g < ngrp) begin
        all1 = 1'b1;
        any1 = 1'b0;
        for (int unsigned t = 0; t < MaxGsz; t++) begin
          if (t < gsize) begin
            sh   = bits >> (g * gsize + t);
            all1 = all1 & sh[0];
            any1 = any1 | sh[0];
          end
        end
        ao = ao | all1;
        oa = oa & any1;
      end
    end
    unique case (mode)
      ModeAo:  res = ao | ext;
      ModeAoi: res = ~(ao | ext);
      ModeOa:  res = oa & ext;
      ModeOai: res = ~(oa & ext);
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ao_array_pipe_if.sv
// ao_array_pipe_if: input/output handshake, data and counter bus for ao_array_pipe.
//   master : driver side (produces in_valid/data/mode, out_ready, cnt_clr)
//   slave  : array side (produces in_ready, out_valid, q, toggle_cnt)
interface ao_array_pipe_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NGRP  = 2,
  parameter int unsigned GSIZE = 2,
  parameter int unsigned CNT_W = 16
) ();
  import ao_array_pkg::*;

  logic                         in_valid;
  logic                         in_ready;
  logic [WIDTH*NGRP*GSIZE-1:0]  and_in;
  logic [WIDTH-1:0]             ext_in;
  logic [ModeW-1:0]             mode;
  logic                         out_valid;
  logic                         out_ready;
  logic [WIDTH-1:0]             q;
  logic                         cnt_clr;
  logic [CNT_W-1:0]             toggle_cnt;

  modport master (
    output in_valid, and_in, ext_in, mode, out_ready, cnt_clr,
    input  in_ready, out_valid, q, toggle_cnt
  );

  modport slave (
    input  in_valid, and_in, ext_in, mode, out_ready, cnt_clr,
    output in_ready, out_valid, q, toggle_cnt
  );
endinterface

// File: rtl/ao_pipe_stage.sv
// ao_pipe_stage: one valid/data register slice of the ao_array_pipe pipeline.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_valid, i_data     : word offered from upstream
//   o_ready             : this slot takes a word at the next edge
//   o_valid, o_data     : registered slot contents
//   i_ready             : downstream takes o_data at the next edge
module ao_pipe_stage #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready
);
  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Slot is free if empty or its occupant moves on this cycle; this collapses bubbles.
  assign o_ready = !r_valid || i_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      // Hold old data on a bubble so Q stays quiet.
      if (i_valid) r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

// File: rtl/ao_array_pipe.sv
// ao_array_pipe: WIDTH-lane AND-OR / OR-AND array with run-time function select,
// a DEPTH-stage valid/ready pipeline and a saturating output toggle counter.
//   i_clk, i_rst : clock, synchronous active-high reset
//   io_bus       : slave side of ao_array_pipe_if (input word + mode, output word,
//                  handshakes, counter clear and toggle count)
module ao_array_pipe
  import ao_array_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NGRP  = 2,
  parameter int unsigned GSIZE = 2,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input logic             i_clk,
  input logic             i_rst,
  ao_array_pipe_if.slave  io_bus
);
  localparam int unsigned LaneW = NGRP * GSIZE;
  localparam int unsigned PcW   = $clog2(WIDTH + 1);
  localparam int unsigned SumW  = CNT_W + PcW;

  if (WIDTH == 0 || NGRP == 0 || GSIZE == 0 || DEPTH == 0 ||
      NGRP > MaxGrp || GSIZE > MaxGsz) begin : g_param_check
    $fatal(1, "ao_array_pipe: illegal WIDTH/NGRP/GSIZE/DEPTH");
  end

  // Index k links stage k (input side) to stage k+1; 0 is the array, DEPTH is the output.
  logic             w_valid [DEPTH+1];
  logic [WIDTH-1:0] w_data  [DEPTH+1];
  logic             w_ready [DEPTH+1];
  logic [WIDTH-1:0] w_eval;

  for (genvar l = 0; l < WIDTH; l++) begin : g_lane
    logic [MaxTerms-1:0] w_lane_bits;
    assign w_lane_bits = MaxTerms'(io_bus.and_in[l*LaneW +: LaneW]);
    assign w_eval[l]   = ao_eval(mode_e'(io_bus.mode), w_lane_bits, NGRP, GSIZE,
                                 io_bus.ext_in[l]);
  end

  // Mode is folded into the result before stage 1, so in-flight words ignore later changes.
  assign w_valid[0]     = io_bus.in_valid;
  assign w_data[0]      = w_eval;
  assign w_ready[DEPTH] = io_bus.out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    ao_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_valid (w_valid[k]),
      .i_data  (w_data[k]),
      .o_ready (w_ready[k]),
      .o_valid (w_valid[k+1]),
      .o_data  (w_data[k+1]),
      .i_ready (w_ready[k+1])
    );
  end

  logic [WIDTH-1:0] w_q;
  logic             w_hs;

  assign w_q              = w_data[DEPTH];
  assign w_hs             = w_valid[DEPTH] && io_bus.out_ready;
  assign io_bus.in_ready  = w_ready[0];
  assign io_bus.out_valid = w_valid[DEPTH];
  assign io_bus.q         = w_q;

  // Toggle counter
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_last_q;
  logic [PcW-1:0]   w_pop;
  logic [SumW-1:0]  w_sum;
  logic [CNT_W-1:0] w_cnt_inc;

  always_comb begin
    w_pop     = PcW'($countones(w_q ^ r_last_q));
    w_sum     = SumW'(r_cnt) + SumW'(w_pop);
    w_cnt_inc = (w_sum[SumW-1:CNT_W] != '0) ? '1 : w_sum[CNT_W-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_last_q <= '0;
    end else begin
      // last_q tracks every handshake, even one whose count is dropped by a clear.
      if (w_hs) r_last_q <= w_q;
      if (io_bus.cnt_clr) r_cnt <= '0;
      else if (w_hs)      r_cnt <= w_cnt_inc;
    end
  end

  assign io_bus.toggle_cnt = r_cnt;
endmodule
